// File: rtl/stream_demux2_pkg.sv
// Shared types for the two-way stream demultiplexer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stream_demux2_pkg;

    // The select bit is the destination index, so the encoding below is fixed.
    typedef enum logic {
        DEST_M0 = 1'b0,
        DEST_M1 = 1'b1
    } dest_e;

    function automatic dest_e sel_to_dest(input logic sel);
        return sel ? DEST_M1 : DEST_M0;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with head-of-queue visible combinationally.
// Latency: a push is visible at the head one cycle later; no empty-bypass.
// Backpressure: push ignored when full, pop ignored when empty; no full-bypass.
module stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt == FULL_LVL);
    assign empty = (cnt == '0);

    // Gating here keeps the counter inside 0..DEPTH even if a caller misbehaves.
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign level    = cnt;

endmodule

// File: rtl/stream_demux2.sv
// Steers one valid/ready stream to one of two outputs, each with its own FIFO.
// Latency: 1 cycle from input acceptance to output valid; 1 beat/cycle per output.
// Backpressure: s_ready reflects only the selected FIFO's fullness, never m*_ready.
module stream_demux2
    import stream_demux2_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    input  logic          s_sel,
    output logic          m0_valid,
    input  logic          m0_ready,
    output logic [W-1:0]  m0_data,
    output logic [AW:0]   m0_level,
    output logic          m1_valid,
    input  logic          m1_ready,
    output logic [W-1:0]  m1_data,
    output logic [AW:0]   m1_level
);

    dest_e dest;
    logic  full0;
    logic  full1;
    logic  empty0;
    logic  empty1;
    logic  accept;
    logic  push0;
    logic  push1;

    assign dest    = sel_to_dest(s_sel);
    assign s_ready = (dest == DEST_M1) ? ~full1 : ~full0;
    assign accept  = s_valid & s_ready;
    assign push0   = accept & (dest == DEST_M0);
    assign push1   = accept & (dest == DEST_M1);

    assign m0_valid = ~empty0;
    assign m1_valid = ~empty1;

    stream_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push0),
        .push_dat (s_data),
        .pop_rdy  (m0_ready),
        .head_dat (m0_data),
        .level    (m0_level),
        .full     (full0),
        .empty    (empty0)
    );

    stream_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push1),
        .push_dat (s_data),
        .pop_rdy  (m1_ready),
        .head_dat (m1_data),
        .level    (m1_level),
        .full     (full1),
        .empty    (empty1)
    );

    // A stalled producer may withdraw the beat, but must not retarget or alter it.
    a_stall_stable: assert property (
        @(posedge clk) disable iff (reset)
        (s_valid && !s_ready) |=> (!s_valid || ($stable(s_sel) && $stable(s_data)))
    ) else $error("stream_demux2: s_sel/s_data changed while stalled");

endmodule

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2: reset, steering, full stall, independence, throughput, mid-run reset.
module tb_stream_demux2;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sel;
    logic       m0_valid;
    logic       m0_ready;
    logic [7:0] m0_data;
    logic [1:0] m0_level;
    logic       m1_valid;
    logic       m1_ready;
    logic [7:0] m1_data;
    logic [1:0] m1_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_demux2 #(.W(8), .DEPTH(2), .AW(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sel    (s_sel),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_data  (m0_data),
        .m0_level (m0_level),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_data  (m1_data),
        .m1_level (m1_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_sel = 1'b0;
        m0_ready = 1'b0; m1_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++; if (m0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m0_valid got=%b exp=0", m0_valid); end
        n_checks++; if (m1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m1_valid got=%b exp=0", m1_valid); end
        n_checks++; if (m0_level !== 2'd0) begin n_fail++; $display("FAIL reset_m0_level got=%0d exp=0", m0_level); end
        n_checks++; if (m1_level !== 2'd0) begin n_fail++; $display("FAIL reset_m1_level got=%0d exp=0", m1_level); end
        n_checks++; if (m0_data !== 8'h00) begin n_fail++; $display("FAIL reset_m0_data got=%h exp=00", m0_data); end
        n_checks++; if (m1_data !== 8'h00) begin n_fail++; $display("FAIL reset_m1_data got=%h exp=00", m1_data); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_steering();
        m0_ready = 1'b1; m1_ready = 1'b1;
        s_valid = 1'b1; s_sel = 1'b0; s_data = 8'hA1;
        #1;
        n_checks++; if (m0_valid !== 1'b0) begin n_fail++; $display("FAIL steer_no_bypass got=%b exp=0", m0_valid); end
        tick();
        s_sel = 1'b1; s_data = 8'hB2;
        #1;
        n_checks++; if (m0_valid !== 1'b1 || m0_data !== 8'hA1) begin n_fail++; $display("FAIL steer_m0 got=%b/%h exp=1/a1", m0_valid, m0_data); end
        n_checks++; if (m1_valid !== 1'b0) begin n_fail++; $display("FAIL steer_m1_early got=%b exp=0", m1_valid); end
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (m0_valid !== 1'b0) begin n_fail++; $display("FAIL steer_m0_once got=%b exp=0", m0_valid); end
        n_checks++; if (m1_valid !== 1'b1 || m1_data !== 8'hB2) begin n_fail++; $display("FAIL steer_m1 got=%b/%h exp=1/b2", m1_valid, m1_data); end
        tick();
        n_checks++; if (m1_valid !== 1'b0) begin n_fail++; $display("FAIL steer_m1_once got=%b exp=0", m1_valid); end
    endtask

    task automatic test_full_stall();
        logic [7:0] got [$];
        logic       acc;
        m0_ready = 1'b0; m1_ready = 1'b1;
        s_valid = 1'b1; s_sel = 1'b0; s_data = 8'h10;
        tick();
        n_checks++; if (m0_level !== 2'd1) begin n_fail++; $display("FAIL full_level1 got=%0d exp=1", m0_level); end
        s_data = 8'h11;
        tick();
        n_checks++; if (m0_level !== 2'd2) begin n_fail++; $display("FAIL full_level2 got=%0d exp=2", m0_level); end
        s_data = 8'h12;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
        tick();
        n_checks++; if (m0_level !== 2'd2 || m0_data !== 8'h10) begin n_fail++; $display("FAIL full_hold got=%0d/%h exp=2/10", m0_level, m0_data); end
        m0_ready = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got=%b exp=0", s_ready); end
        for (int c = 0; c < 8; c++) begin
            acc = s_valid & s_ready;
            if (m0_valid && m0_ready) got.push_back(m0_data);
            tick();
            if (acc) s_valid = 1'b0;
            #1;
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 8'h10 || got[1] !== 8'h11 || got[2] !== 8'h12) begin
            n_fail++;
            $display("FAIL full_order got=%p exp='{10,11,12}", got);
        end
        n_checks++; if (m0_level !== 2'd0) begin n_fail++; $display("FAIL full_drained got=%0d exp=0", m0_level); end
    endtask

    task automatic test_independence();
        m0_ready = 1'b0; m1_ready = 1'b1;
        s_valid = 1'b1; s_sel = 1'b0; s_data = 8'h20;
        tick();
        s_data = 8'h21;
        tick();
        s_valid = 1'b0;
        tick();
        s_valid = 1'b1; s_sel = 1'b1; s_data = 8'h55;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL indep_s_ready got=%b exp=1", s_ready); end
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if (m1_valid !== 1'b1 || m1_data !== 8'h55) begin n_fail++; $display("FAIL indep_m1 got=%b/%h exp=1/55", m1_valid, m1_data); end
        n_checks++; if (m0_level !== 2'd2) begin n_fail++; $display("FAIL indep_m0_level got=%0d exp=2", m0_level); end
        tick();
        n_checks++; if (m1_valid !== 1'b0 || m0_level !== 2'd2) begin n_fail++; $display("FAIL indep_after got=%b/%0d exp=0/2", m1_valid, m0_level); end
        m0_ready = 1'b1;
        tick(); tick();
        n_checks++; if (m0_level !== 2'd0) begin n_fail++; $display("FAIL indep_drain got=%0d exp=0", m0_level); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got0 [$];
        logic [7:0] got1 [$];
        logic [7:0] exp0 [$];
        logic [7:0] exp1 [$];
        int         ready_bad = 0;
        m0_ready = 1'b1; m1_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            if (i < 20) begin
                s_valid = 1'b1;
                s_sel   = (i % 2) == 1;
                s_data  = 8'h40 + 8'(i);
                if (i % 2 == 0) exp0.push_back(8'h40 + 8'(i));
                else            exp1.push_back(8'h40 + 8'(i));
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (i < 20 && s_ready !== 1'b1) ready_bad++;
            if (m0_valid && m0_ready) got0.push_back(m0_data);
            if (m1_valid && m1_ready) got1.push_back(m1_data);
            tick();
        end
        n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL b2b_s_ready low_cycles=%0d exp=0", ready_bad); end
        n_checks++; if (got0 != exp0) begin n_fail++; $display("FAIL b2b_m0 got=%p exp=%p", got0, exp0); end
        n_checks++; if (got1 != exp1) begin n_fail++; $display("FAIL b2b_m1 got=%p exp=%p", got1, exp1); end
    endtask

    task automatic test_reset_mid();
        int leaked = 0;
        m0_ready = 1'b0;
        s_valid = 1'b1; s_sel = 1'b0; s_data = 8'h70;
        tick();
        s_data = 8'h71;
        tick();
        s_valid = 1'b0;
        n_checks++; if (m0_level !== 2'd2) begin n_fail++; $display("FAIL rmid_pre_level got=%0d exp=2", m0_level); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (m0_valid !== 1'b0 || m0_level !== 2'd0) begin n_fail++; $display("FAIL rmid_cleared got=%b/%0d exp=0/0", m0_valid, m0_level); end
        n_checks++; if (m0_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data got=%h exp=00", m0_data); end
        m0_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (m0_valid) leaked++;
            tick();
        end
        n_checks++; if (leaked != 0) begin n_fail++; $display("FAIL rmid_leak got=%0d exp=0", leaked); end
    endtask

    initial begin
        test_reset();
        test_steering();
        test_full_stall();
        test_independence();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
